// File: rtl/mux_arb_pkg.sv
// Shared types, widths and select/grant conversion helpers for the
// round-robin mux arbiter.
package mux_arb_pkg;

  localparam int N_REQ = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  function automatic logic [SEL_W-1:0] onehot_to_sel(input logic [N_REQ-1:0] oh);
    logic [SEL_W-1:0] s;
    s = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (oh[i]) s = SEL_W'(i);
    end
    return s;
  endfunction

  function automatic logic [N_REQ-1:0] sel_to_onehot(input logic [SEL_W-1:0] s);
    return N_REQ'(1) << s;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Cyclic first-set-bit search: returns the first set bit of mask starting
// at ptr and wrapping modulo N_REQ.
module rr_pick
  import mux_arb_pkg::*;
(
  input  logic [N_REQ-1:0] mask,
  input  logic [SEL_W-1:0] ptr,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] cand;

  // NOTE: every output and temporary gets a default before any branch, so
  // no path through this block leaves a value unassigned (no latch).
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = ptr + SEL_W'(k);
      if (!found && mask[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin owner selection for a shared 4-to-1 mux, with a bounded hold
// time before forced rotation and registered grant/select/busy/handover.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [SEL_W-1:0] sel,
  output logic             busy,
  output logic             handover
);

  localparam int HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

  arb_state_e       state, state_n;
  logic [SEL_W-1:0] ptr, ptr_n;
  logic [HOLD_W-1:0] hold_cnt, hold_n;
  logic [N_REQ-1:0] gnt_n;
  logic [SEL_W-1:0] sel_n;
  logic             busy_n, handover_n;

  logic [N_REQ-1:0] owner_oh, others, pick_mask;
  logic             own_req, hold_open, pick_found, take;
  logic [SEL_W-1:0] pick_idx;

  // sel doubles as the owner register: it keeps the last owner while idle.
  assign owner_oh  = sel_to_onehot(sel);
  assign others    = req & ~owner_oh;
  assign own_req   = |(req & owner_oh);
  assign hold_open = (MAX_HOLD == 0) || (hold_cnt < HOLD_MAX);
  assign pick_mask = (state == IDLE) ? req : others;

  rr_pick u_pick (
    .mask  (pick_mask),
    .ptr   (ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    state_n    = state;
    ptr_n      = ptr;
    hold_n     = hold_cnt;
    gnt_n      = gnt;
    sel_n      = sel;
    busy_n     = busy;
    handover_n = 1'b0;
    take       = 1'b0;

    case (state)
      IDLE: begin
        if (pick_found) take = 1'b1;
      end
      GRANT: begin
        if (own_req && (!(|others) || hold_open)) begin
          if (MAX_HOLD != 0 && hold_cnt != HOLD_MAX) hold_n = hold_cnt + 1'b1;
        end else if (|others) begin
          // Release and expired hold both hand straight to the next waiter.
          take = 1'b1;
        end else begin
          state_n = IDLE;
          gnt_n   = '0;
          busy_n  = 1'b0;
          hold_n  = '0;
        end
      end
      default: state_n = IDLE;
    endcase

    if (take) begin
      state_n    = GRANT;
      gnt_n      = sel_to_onehot(pick_idx);
      sel_n      = onehot_to_sel(gnt_n);
      busy_n     = 1'b1;
      handover_n = 1'b1;
      hold_n     = HOLD_W'(1);
      ptr_n      = pick_idx + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      hold_cnt <= '0;
      gnt      <= '0;
      sel      <= '0;
      busy     <= 1'b0;
      handover <= 1'b0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      hold_cnt <= hold_n;
      gnt      <= gnt_n;
      sel      <= sel_n;
      busy     <= busy_n;
      handover <= handover_n;
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Scenario tasks plus a randomized run against an integer reference model
// of the round-robin arbitration rules.
module tb_mux_rr_arbiter;

  localparam int MAX = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy, handover;

  int checks   = 0;
  int failures = 0;

  mux_rr_arbiter #(.MAX_HOLD(MAX)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .gnt      (gnt),
    .sel      (sel),
    .busy     (busy),
    .handover (handover)
  );

  always #5 clk = ~clk;

  // Reference model state (plain integers).
  int         m_owner = 0;
  int         m_ptr   = 0;
  int         m_hold  = 0;
  logic       m_busy  = 1'b0;
  logic       m_ho    = 1'b0;
  logic [3:0] prev_req = 4'b0000;

  function automatic int pick(input logic [3:0] m, input int p);
    for (int k = 0; k < 4; k++) begin
      if (m[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  function automatic logic [3:0] m_gnt();
    return m_busy ? (4'b0001 << m_owner) : 4'b0000;
  endfunction

  task automatic model_grant(input int o);
    m_owner = o;
    m_busy  = 1'b1;
    m_ho    = 1'b1;
    m_hold  = 1;
    m_ptr   = (o + 1) % 4;
  endtask

  task automatic model_update(input logic r_rst, input logic [3:0] r);
    logic [3:0] others;
    m_ho = 1'b0;
    if (r_rst) begin
      m_owner = 0; m_ptr = 0; m_hold = 0; m_busy = 1'b0;
    end else if (!m_busy) begin
      if (r != 4'b0000) model_grant(pick(r, m_ptr));
    end else begin
      others = r & ~(4'b0001 << m_owner);
      if (r[m_owner] && (others == 4'b0000 || MAX == 0 || m_hold < MAX)) begin
        if (MAX > 0 && m_hold < MAX) m_hold++;
      end else if (others != 4'b0000) begin
        model_grant(pick(others, m_ptr));
      end else begin
        m_busy = 1'b0;
        m_hold = 0;
      end
    end
  endtask

  // One clock: drive inputs, advance model at the edge, settle 1ns past it.
  task automatic tick(input logic r_rst, input logic [3:0] r);
    rst = r_rst;
    req = r;
    @(posedge clk);
    model_update(r_rst, r);
    prev_req = r;
    #1;
  endtask

  task automatic test_reset();
    tick(1'b1, 4'b1111);
    checks++;
    if (gnt !== 4'b0000 || sel !== 2'd0 || busy !== 1'b0 || handover !== 1'b0) begin
      failures++;
      $display("FAIL reset: gnt=%b sel=%0d busy=%b ho=%b required 0000/0/0/0", gnt, sel, busy, handover);
    end
  endtask

  task automatic test_single_request();
    tick(1'b1, 4'b0000);
    tick(1'b0, 4'b0100);
    checks++;
    if (gnt !== 4'b0100 || sel !== 2'd2 || busy !== 1'b1 || handover !== 1'b1) begin
      failures++;
      $display("FAIL single_grant: gnt=%b sel=%0d busy=%b ho=%b required 0100/2/1/1", gnt, sel, busy, handover);
    end
    for (int i = 0; i < 3; i++) tick(1'b0, 4'b0100);
    checks++;
    if (gnt !== 4'b0100 || handover !== 1'b0) begin
      failures++;
      $display("FAIL single_hold: gnt=%b ho=%b required 0100/0", gnt, handover);
    end
    tick(1'b0, 4'b0000);
    checks++;
    if (gnt !== 4'b0000 || busy !== 1'b0 || sel !== 2'd2 || handover !== 1'b0) begin
      failures++;
      $display("FAIL single_release: gnt=%b busy=%b sel=%0d ho=%b required 0000/0/2/0", gnt, busy, sel, handover);
    end
  endtask

  task automatic test_rotation();
    int exp_owner;
    tick(1'b1, 4'b0000);
    for (int k = 0; k < 40; k++) begin
      tick(1'b0, 4'b1111);
      exp_owner = (k / MAX) % 4;
      checks++;
      if (gnt !== (4'b0001 << exp_owner) || sel !== 2'(exp_owner) ||
          handover !== ((k % MAX) == 0)) begin
        failures++;
        $display("FAIL rotation[%0d]: gnt=%b sel=%0d ho=%b required owner %0d ho=%b",
                 k, gnt, sel, handover, exp_owner, (k % MAX) == 0);
      end
    end
  endtask

  task automatic test_handoff();
    tick(1'b1, 4'b0000);
    tick(1'b0, 4'b0010);
    tick(1'b0, 4'b1010);
    checks++;
    if (gnt !== 4'b0010 || handover !== 1'b0) begin
      failures++;
      $display("FAIL handoff_keep: gnt=%b ho=%b required 0010/0", gnt, handover);
    end
    tick(1'b0, 4'b1000);
    checks++;
    if (gnt !== 4'b1000 || sel !== 2'd3 || busy !== 1'b1 || handover !== 1'b1) begin
      failures++;
      $display("FAIL handoff_direct: gnt=%b sel=%0d busy=%b ho=%b required 1000/3/1/1", gnt, sel, busy, handover);
    end
  endtask

  task automatic test_saturate();
    int exp_hold;
    tick(1'b1, 4'b0000);
    for (int k = 0; k < 20; k++) begin
      tick(1'b0, 4'b0100);
      exp_hold = (k + 1 < MAX) ? k + 1 : MAX;
      checks++;
      if (gnt !== 4'b0100 || handover !== (k == 0) || int'(dut.hold_cnt) != exp_hold) begin
        failures++;
        $display("FAIL saturate[%0d]: gnt=%b ho=%b hold=%0d required 0100 ho=%b hold=%0d",
                 k, gnt, handover, dut.hold_cnt, k == 0, exp_hold);
      end
    end
  endtask

  task automatic test_release_preempt();
    tick(1'b1, 4'b0000);
    for (int k = 0; k < MAX; k++) tick(1'b0, 4'b0011);
    checks++;
    if (gnt !== 4'b0001) begin
      failures++;
      $display("FAIL rp_owner0: gnt=%b required 0001", gnt);
    end
    tick(1'b0, 4'b0010);
    checks++;
    if (gnt !== 4'b0010 || handover !== 1'b1 || int'(dut.ptr) != 2) begin
      failures++;
      $display("FAIL rp_release: gnt=%b ho=%b ptr=%0d required 0010/1/2", gnt, handover, dut.ptr);
    end
    for (int k = 0; k < 3; k++) tick(1'b0, 4'b0011);
    checks++;
    if (gnt !== 4'b0010) begin
      failures++;
      $display("FAIL rp_keep1: gnt=%b required 0010", gnt);
    end
    tick(1'b0, 4'b0001);
    checks++;
    if (gnt !== 4'b0001 || sel !== 2'd0 || handover !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL rp_reraise: gnt=%b sel=%0d ho=%b busy=%b required 0001/0/1/1", gnt, sel, handover, busy);
    end
  endtask

  task automatic test_reset_mid_grant();
    tick(1'b1, 4'b0000);
    tick(1'b0, 4'b0010);
    tick(1'b1, 4'b0010);
    checks++;
    if (gnt !== 4'b0000 || sel !== 2'd0 || busy !== 1'b0 || handover !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid: gnt=%b sel=%0d busy=%b ho=%b required 0000/0/0/0", gnt, sel, busy, handover);
    end
    tick(1'b0, 4'b1010);
    checks++;
    if (gnt !== 4'b0010 || sel !== 2'd1 || handover !== 1'b1) begin
      failures++;
      $display("FAIL post_reset_grant: gnt=%b sel=%0d ho=%b required 0010/1/1", gnt, sel, handover);
    end
  endtask

  task automatic test_random();
    logic [3:0] r;
    logic [3:0] pr;
    logic [1:0] enc;
    tick(1'b1, 4'b0000);
    r = 4'b0000;
    for (int k = 0; k < 600; k++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 3) == 0) r[b] = ~r[b];
      end
      pr = prev_req;
      tick(1'b0, r);
      checks++;
      if (gnt !== m_gnt() || busy !== m_busy || handover !== m_ho ||
          (m_busy && sel !== 2'(m_owner))) begin
        failures++;
        $display("FAIL random[%0d]: gnt=%b sel=%0d busy=%b ho=%b required gnt=%b owner=%0d busy=%b ho=%b",
                 k, gnt, sel, busy, handover, m_gnt(), m_owner, m_busy, m_ho);
      end
      enc = 2'd0;
      for (int i = 0; i < 4; i++) if (gnt[i]) enc = 2'(i);
      checks++;
      if (!$onehot0(gnt) || busy !== (|gnt) || (busy && sel !== enc) ||
          ((gnt & ~r) != 4'b0000) || (handover && !busy)) begin
        failures++;
        $display("FAIL invariant[%0d]: gnt=%b sel=%0d busy=%b ho=%b req=%b prev=%b",
                 k, gnt, sel, busy, handover, r, pr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_request();
    test_rotation();
    test_handoff();
    test_saturate();
    test_release_preempt();
    test_reset_mid_grant();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
